mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single byte-wide unified memory port between the IF stage (instruction fetch) and the MEM stage (load/store issued from the EX/MEM pipeline register).
- Sequences each access as 1, 2 or 4 byte beats and assembles or splits 32-bit words little-endian.
- Raises per-stage stall requests that the pipeline stall controller folds into stall[5:0], freezing the pipeline while an access is outstanding.

Parameters:
- ADDR_W, 32, address width of requester and memory buses.
- DATA_W, 32, requester data width; fixed at 4 bytes.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  IF fetch request; held until if_done
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  32  fetched instruction; valid while if_done=1
- if_done  out  1  one-cycle completion pulse
- me_req  in  1  MEM access request; held until me_done
- me_we  in  1  1=store, 0=load
- me_width  in  2  00 byte, 01 half, 10 word; 11 treated as word
- me_addr  in  ADDR_W  data address
- me_wdata  in  32  store data; low bytes used
- me_rdata  out  32  load data, zero-extended (sign extension stays in MEM stage); valid while me_done=1
- me_done  out  1  one-cycle completion pulse
- mem_addr  out  ADDR_W  byte address to RAM
- mem_we  out  1  byte write strobe
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte; valid one cycle after its address is driven
- stall_req_if  out  1  IF stall request
- stall_req_me  out  1  MEM stall request

Behaviour:
- Reset values: all outputs 0; state IDLE; beat counter 0.
- States: IDLE, RD, WR, DONE.
- Arbitration in IDLE: me_req wins over if_req, because the older instruction has priority. The loser stays pending.
- Once granted, a transaction is never preempted. The owner, address, width, we and wdata are latched at grant, so later requester changes do not affect it.
- Beat count N: 1, 2 or 4 from the width; IF is always 4.
- Cycle numbering: the grant edge ends cycle -1; cycle 0 is the first beat.
- RD state:
  - In cycles 0..N-1, drive mem_addr = addr+k with mem_we=0.
  - Byte k is captured from mem_rdata at the end of cycle k+1 into bits [8k+7:8k].
  - Transition to DONE after the last capture, so done is visible in cycle N+1.
- WR state:
  - In cycles 0..N-1, drive mem_addr = addr+k, mem_we=1, mem_wdata = wdata[8k+7:8k].
  - The done pulse is in cycle N.
- DONE state: assert the owner's done for exactly 1 cycle with the rdata register valid, then go to IDLE. No grant is made in DONE, so back-to-back transactions have a one-cycle gap.
- mem_we is 0 in every state except WR.
- Address arithmetic wraps modulo 2^ADDR_W; no alignment check is made.
- Stall requests (combinational):
  - stall_req_if = if_req & ~if_done.
  - stall_req_me = me_req & ~me_done.
  - A pending loser keeps its stall request high throughout the other transaction.
- If a requester drops req mid-transaction (flush), the transaction still completes and done still pulses; the requester ignores it.
- Reset mid-transaction: next cycle is IDLE, mem_we=0, done=0; partially written bytes remain in RAM.
- rdata registers hold their value until the next read capture.

Decomposition:
- Shared package constants:
  - MEMW_BYTE=2'b00, MEMW_HALF=2'b01, MEMW_WORD=2'b10
  - state encodings ARB_IDLE/RD/WR/DONE
  - OWNER_IF/OWNER_ME
- These sit alongside the existing ZeroWord/WriteDisable defines.
- One sub-module is natural: mem_beat_seq (beat counter, address increment, byte lane select/insert), reused by a future split I/D cache refill.

Test Plan:
- IF only, if_addr=0x100, RAM[0x100..0x103]=13,05,50,00 → mem_addr 0x100..0x103 in cycles 0-3, if_done in cycle 5, if_rdata=0x00500513, stall_req_if high cycles -1..4.
- if_req and me_req (load word 0x200) rise in the same cycle → ME served first with me_done in cycle 5, IF grant follows DONE+IDLE, stall_req_if high throughout.
- Store byte me_addr=0x203, me_wdata=0xAABBCCDD → one cycle with mem_we=1, mem_addr=0x203, mem_wdata=0xDD; me_done in cycle 1; RAM[0x200..0x202] unchanged.
- Store half at 0x300, wdata=0x1234 → writes 0x34 then 0x12; a load half from 0x300 then gives me_rdata=0x00001234, done in cycle 3.
- Reset asserted in cycle 2 of a word store → next cycle mem_we=0, all done=0, state IDLE; RAM holds 2 new bytes; a new if_req after reset is served normally.
- me_req dropped in cycle 1 of a word load → 4 beats still issued, me_done still pulses once, no stall_req_me after the drop.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and helpers for the unified byte-wide memory port arbiter.
package mem_port_arbiter_pkg;

   localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
   localparam logic        WRITE_DISABLE = 1'b0;

   localparam logic [1:0] MEMW_BYTE = 2'b00;
   localparam logic [1:0] MEMW_HALF = 2'b01;
   localparam logic [1:0] MEMW_WORD = 2'b10;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_RD   = 2'd1,
      ARB_WR   = 2'd2,
      ARB_DONE = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWNER_IF = 1'b0,
      OWNER_ME = 1'b1
   } owner_t;

   // Width code 2'b11 is treated as a full word.
   function automatic logic [2:0] beat_count(input logic [1:0] width);
      case (width)
         MEMW_BYTE: beat_count = 3'd1;
         MEMW_HALF: beat_count = 3'd2;
         MEMW_WORD: beat_count = 3'd4;
         default:   beat_count = 3'd4;
      endcase
   endfunction

   function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
      byte_lane = word[8*lane +: 8];
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-side signals of the shared memory port.
// slave is the arbiter's view; master is the pipeline plus RAM side.
interface mem_port_arbiter_if #(parameter int ADDR_W = 32);

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [31:0]       if_rdata;
   logic              if_done;

   logic              me_req;
   logic              me_we;
   logic [1:0]        me_width;
   logic [ADDR_W-1:0] me_addr;
   logic [31:0]       me_wdata;
   logic [31:0]       me_rdata;
   logic              me_done;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   logic              stall_req_if;
   logic              stall_req_me;

   modport slave (
      input  if_req, if_addr, me_req, me_we, me_width, me_addr, me_wdata, mem_rdata,
      output if_rdata, if_done, me_rdata, me_done, mem_addr, mem_we, mem_wdata,
             stall_req_if, stall_req_me
   );

   modport master (
      output if_req, if_addr, me_req, me_we, me_width, me_addr, me_wdata, mem_rdata,
      input  if_rdata, if_done, me_rdata, me_done, mem_addr, mem_we, mem_wdata,
             stall_req_if, stall_req_me
   );

endinterface

// File: rtl/mem_port_arbiter_beat_seq.sv
// Beat counter, next-beat address/write-byte select and read-byte insert for byte-serial access.
// Counter clears while clr is high and steps once per cycle while adv is high.
module mem_beat_seq
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              adv,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [31:0]       wdata,
   input  logic [31:0]       word_in,
   input  logic [7:0]        byte_in,
   output logic [2:0]        cnt,
   output logic [ADDR_W-1:0] nxt_addr,
   output logic [7:0]        nxt_wbyte,
   output logic [31:0]       word_out
);

   logic [1:0] nxt_lane;
   logic [1:0] cap_lane;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= 3'd0;
      end else if (adv) begin
         cnt <= cnt + 3'd1;
      end
   end

   assign nxt_lane  = cnt[1:0] + 2'd1;
   assign cap_lane  = cnt[1:0] - 2'd1;
   assign nxt_addr  = base_addr + ADDR_W'(cnt) + ADDR_W'(1);
   assign nxt_wbyte = byte_lane(wdata, nxt_lane);

   // The first captured byte starts from zero so narrow loads come out zero-extended.
   always_comb begin
      word_out = (cnt == 3'd1) ? ZERO_WORD : word_in;
      word_out[8*cap_lane +: 8] = byte_in;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the byte-wide memory port between IF and MEM (MEM wins), splitting 1/2/4-byte accesses little-endian.
// Done pulses N+1 cycles after grant for reads, N for writes; requesters stall until their done.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic                clk,
   input logic                rst,
   mem_port_arbiter_if.slave  bus
);

   arb_state_t        state;
   owner_t            owner;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] nxt_addr;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] me_rdata_q;
   logic [DATA_W-1:0] word_in;
   logic [DATA_W-1:0] word_out;
   logic [2:0]        nbeats;
   logic [2:0]        cnt;
   logic [7:0]        nxt_wbyte;
   logic [7:0]        mem_wdata_q;
   logic              mem_we_q;
   logic              if_done_q;
   logic              me_done_q;
   logic              seq_clr;
   logic              seq_adv;
   logic              last_rd;
   logic              last_wr;

   assign seq_clr = (state == ARB_IDLE);
   assign seq_adv = (state == ARB_RD) || (state == ARB_WR);
   assign word_in = (owner == OWNER_IF) ? if_rdata_q : me_rdata_q;
   assign last_rd = (cnt == nbeats);
   assign last_wr = (cnt == nbeats - 3'd1);

   mem_beat_seq #(.ADDR_W(ADDR_W)) u_beat_seq (
      .clk       (clk),
      .rst       (rst),
      .clr       (seq_clr),
      .adv       (seq_adv),
      .base_addr (addr_q),
      .wdata     (wdata_q),
      .word_in   (word_in),
      .byte_in   (bus.mem_rdata),
      .cnt       (cnt),
      .nxt_addr  (nxt_addr),
      .nxt_wbyte (nxt_wbyte),
      .word_out  (word_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ARB_IDLE;
         owner       <= OWNER_IF;
         addr_q      <= '0;
         wdata_q     <= '0;
         nbeats      <= 3'd0;
         mem_addr_q  <= '0;
         mem_we_q    <= WRITE_DISABLE;
         mem_wdata_q <= 8'h00;
         if_rdata_q  <= '0;
         me_rdata_q  <= '0;
         if_done_q   <= 1'b0;
         me_done_q   <= 1'b0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (bus.me_req) begin
                  owner       <= OWNER_ME;
                  addr_q      <= bus.me_addr;
                  wdata_q     <= bus.me_wdata;
                  nbeats      <= beat_count(bus.me_width);
                  mem_addr_q  <= bus.me_addr;
                  mem_we_q    <= bus.me_we;
                  mem_wdata_q <= bus.me_wdata[7:0];
                  state       <= bus.me_we ? ARB_WR : ARB_RD;
               end else if (bus.if_req) begin
                  owner      <= OWNER_IF;
                  addr_q     <= bus.if_addr;
                  nbeats     <= 3'd4;
                  mem_addr_q <= bus.if_addr;
                  mem_we_q   <= WRITE_DISABLE;
                  state      <= ARB_RD;
               end
            end
            // Each byte arrives one cycle after its address, so capture lags the address by one beat.
            ARB_RD: begin
               if (cnt != 3'd0) begin
                  if (owner == OWNER_IF) if_rdata_q <= word_out;
                  else                   me_rdata_q <= word_out;
               end
               if (last_rd) begin
                  state     <= ARB_DONE;
                  if_done_q <= (owner == OWNER_IF);
                  me_done_q <= (owner == OWNER_ME);
               end else if (cnt < nbeats - 3'd1) begin
                  mem_addr_q <= nxt_addr;
               end
            end
            ARB_WR: begin
               if (last_wr) begin
                  mem_we_q  <= WRITE_DISABLE;
                  state     <= ARB_DONE;
                  if_done_q <= (owner == OWNER_IF);
                  me_done_q <= (owner == OWNER_ME);
               end else begin
                  mem_addr_q  <= nxt_addr;
                  mem_wdata_q <= nxt_wbyte;
               end
            end
            ARB_DONE: begin
               if_done_q <= 1'b0;
               me_done_q <= 1'b0;
               state     <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   assign bus.if_rdata     = if_rdata_q;
   assign bus.if_done      = if_done_q;
   assign bus.me_rdata     = me_rdata_q;
   assign bus.me_done      = me_done_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_we       = mem_we_q;
   assign bus.mem_wdata    = mem_wdata_q;
   assign bus.stall_req_if = bus.if_req & ~if_done_q;
   assign bus.stall_req_me = bus.me_req & ~me_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter against a byte-array memory model.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ram_load = 1'b1;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32)) bus ();
   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [7:0] ram     [0:4095];
   logic [7:0] ref_mem [0:4095];
   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;

   typedef struct { int cyc; logic [31:0] addr; logic we; logic [7:0] dat; } beat_t;
   typedef struct { int cyc; logic chk_data; logic [31:0] data; } done_t;
   beat_t bq[$];
   done_t ifq[$];
   done_t meq[$];

   // RAM: registered read, byte write; addresses alias onto 4 KiB.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_load) begin
         for (int i = 0; i < 4096; i++) ram[i] <= ref_mem[i];
      end else if (bus.mem_we) begin
         ram[bus.mem_addr[11:0]] <= bus.mem_wdata;
      end
      bus.mem_rdata <= ram[bus.mem_addr[11:0]];
   end

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      beat_t b;
      done_t d;
      if (bq.size() != 0 && bq[0].cyc == cyc) begin
         b = bq.pop_front();
         check_eq("beat_we", bus.mem_we, b.we);
         check_eq("beat_addr", bus.mem_addr, b.addr);
         if (b.we) check_eq("beat_wdata", bus.mem_wdata, b.dat);
      end else begin
         check_eq("stray_write", bus.mem_we, 1'b0);
      end
      check_eq("stall_if", bus.stall_req_if, bus.if_req & ~bus.if_done);
      check_eq("stall_me", bus.stall_req_me, bus.me_req & ~bus.me_done);
      if (bus.me_done === 1'b1) begin
         if (meq.size() == 0) check_eq("me_done_stray", bus.me_done, 1'b0);
         else begin
            d = meq.pop_front();
            check_eq("me_done_cycle", cyc, d.cyc);
            if (d.chk_data) check_eq("me_rdata", bus.me_rdata, d.data);
         end
      end
      if (bus.if_done === 1'b1) begin
         if (ifq.size() == 0) check_eq("if_done_stray", bus.if_done, 1'b0);
         else begin
            d = ifq.pop_front();
            check_eq("if_done_cycle", cyc, d.cyc);
            check_eq("if_rdata", bus.if_rdata, d.data);
         end
      end
   end

   // Model: beats = 1/2/4; a read's done lands beats+2 cycles after the request cycle, a write's beats+1;
   // a losing IF request is granted in the cycle after the winner's done cycle.
   task automatic run_txn(input logic do_if, input logic [31:0] iaddr, input logic do_me,
                          input logic mwe, input logic [1:0] mwidth, input logic [31:0] maddr,
                          input logic [31:0] mwdata, input logic flush);
      int c, n, me_end, if_start, guard;
      logic [31:0] w;
      logic me_pend, if_pend;
      @(posedge clk); #1;
      c = cyc;
      if_start = c;
      if (do_me) begin
         n = (mwidth == 2'b00) ? 1 : (mwidth == 2'b01) ? 2 : 4;
         me_end = c + 1 + (mwe ? n : n + 1);
         w = 32'h0;
         for (int k = 0; k < n; k++) begin
            logic [31:0] a;
            a = maddr + 32'(k);
            if (mwe) begin
               ref_mem[a[11:0]] = mwdata[8*k +: 8];
               bq.push_back('{cyc: c + 1 + k, addr: a, we: 1'b1, dat: mwdata[8*k +: 8]});
            end else begin
               w[8*k +: 8] = ref_mem[a[11:0]];
               bq.push_back('{cyc: c + 1 + k, addr: a, we: 1'b0, dat: 8'h00});
            end
         end
         meq.push_back('{cyc: me_end, chk_data: !mwe, data: w});
         if_start = me_end + 1;
      end
      if (do_if) begin
         w = 32'h0;
         for (int k = 0; k < 4; k++) begin
            logic [31:0] a;
            a = iaddr + 32'(k);
            w[8*k +: 8] = ref_mem[a[11:0]];
            bq.push_back('{cyc: if_start + 1 + k, addr: a, we: 1'b0, dat: 8'h00});
         end
         ifq.push_back('{cyc: if_start + 6, chk_data: 1'b1, data: w});
      end
      bus.me_req = do_me; bus.me_we = mwe; bus.me_width = mwidth;
      bus.me_addr = maddr; bus.me_wdata = mwdata;
      bus.if_req = do_if; bus.if_addr = iaddr;
      me_pend = do_me;
      if_pend = do_if;
      guard = 0;
      while ((me_pend || if_pend) && guard < 40) begin
         @(negedge clk);
         if (bus.me_done === 1'b1) me_pend = 1'b0;
         if (bus.if_done === 1'b1) if_pend = 1'b0;
         @(posedge clk); #1;
         guard++;
         if (!me_pend) bus.me_req = 1'b0;
         if (!if_pend) bus.if_req = 1'b0;
         if (flush && cyc == c + 2) bus.me_req = 1'b0;
      end
      check_eq("txn_completes", {30'b0, me_pend, if_pend}, 32'h0);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int c, bad;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.me_req = 1'b0; bus.me_we = 1'b0; bus.me_width = 2'b00;
      bus.me_addr = '0; bus.me_wdata = '0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = 8'($urandom);
      ref_mem[12'h100] = 8'h13; ref_mem[12'h101] = 8'h05;
      ref_mem[12'h102] = 8'h50; ref_mem[12'h103] = 8'h00;
      repeat (3) @(posedge clk);
      #1 ram_load = 1'b0;
      @(negedge clk);
      check_eq("rst_if_done", bus.if_done, 1'b0);
      check_eq("rst_me_done", bus.me_done, 1'b0);
      check_eq("rst_if_rdata", bus.if_rdata, 32'h0);
      check_eq("rst_me_rdata", bus.me_rdata, 32'h0);
      check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
      check_eq("rst_mem_wdata", bus.mem_wdata, 8'h00);
      @(posedge clk); #1 rst = 1'b0;

      run_txn(1'b1, 32'h100, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 1'b0);
      run_txn(1'b1, 32'h100, 1'b1, 1'b0, 2'b10, 32'h200, 32'h0, 1'b0);
      run_txn(1'b0, 32'h0, 1'b1, 1'b1, 2'b00, 32'h203, 32'hAABBCCDD, 1'b0);
      run_txn(1'b0, 32'h0, 1'b1, 1'b1, 2'b01, 32'h300, 32'h00001234, 1'b0);
      run_txn(1'b0, 32'h0, 1'b1, 1'b0, 2'b01, 32'h300, 32'h0, 1'b0);
      run_txn(1'b0, 32'h0, 1'b1, 1'b1, 2'b10, 32'hFFFFFFFE, 32'h87654321, 1'b0);
      run_txn(1'b0, 32'h0, 1'b1, 1'b0, 2'b11, 32'hFFFFFFFE, 32'h0, 1'b0);
      run_txn(1'b0, 32'h0, 1'b1, 1'b0, 2'b10, 32'h200, 32'h0, 1'b1);

      // Word store interrupted: reset is sampled on the edge that would start beat 2.
      @(posedge clk); #1;
      c = cyc;
      bus.me_req = 1'b1; bus.me_we = 1'b1; bus.me_width = 2'b10;
      bus.me_addr = 32'h400; bus.me_wdata = 32'hCAFEF00D;
      ref_mem[12'h400] = 8'h0D; ref_mem[12'h401] = 8'hF0;
      bq.push_back('{cyc: c + 1, addr: 32'h400, we: 1'b1, dat: 8'h0D});
      bq.push_back('{cyc: c + 2, addr: 32'h401, we: 1'b1, dat: 8'hF0});
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; bus.me_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_mid_mem_we", bus.mem_we, 1'b0);
      check_eq("rst_mid_me_done", bus.me_done, 1'b0);
      check_eq("rst_mid_if_done", bus.if_done, 1'b0);
      run_txn(1'b1, 32'h400, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 1'b0);

      for (int t = 0; t < 80; t++) begin
         int kind;
         logic mwe, fl;
         logic [1:0] mw;
         logic [31:0] ia, ma, wd;
         kind = $urandom_range(0, 3);
         ia = $urandom; ma = $urandom; wd = $urandom;
         mw = 2'($urandom_range(0, 3));
         mwe = 1'($urandom_range(0, 1));
         fl = !mwe && ($urandom_range(0, 3) == 0);
         case (kind)
            0:       run_txn(1'b1, ia, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
            1:       run_txn(1'b0, ia, 1'b1, mwe, mw, ma, wd, fl);
            default: run_txn(1'b1, ia, 1'b1, mwe, mw, ma, wd, fl);
         endcase
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      repeat (4) @(posedge clk);
      @(negedge clk);
      check_eq("beat_queue_empty", bq.size(), 0);
      check_eq("if_queue_empty", ifq.size(), 0);
      check_eq("me_queue_empty", meq.size(), 0);
      bad = 0;
      for (int i = 0; i < 4096; i++) if (ram[i] !== ref_mem[i]) bad++;
      check_eq("ram_image_bad_bytes", bad, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
